// File: rtl/ifm_out_fsm_ctrl.sv
// Read-side sequencer for the 10GbE RX path: pops a per-frame status entry, then forwards or discards the frame's data beats.
// Optional frame counters are built only when IFM_OUT_STATS_EN is defined.
module ifm_out_fsm_ctrl (
  input  logic        rx_clk,
  input  logic        sys_rst_n,
  input  logic        out_en,
  input  logic [7:0]  info_fifo_rdata,
  input  logic        info_fifo_empty,
  output logic        info_fifo_rden,
  input  logic [72:0] data_fifo_rdata,
  input  logic        data_fifo_empty,
  output logic        data_fifo_rden,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        stat_clr,
  output logic [31:0] frame_good_cnt,
  output logic [31:0] frame_drop_cnt,
  output logic [3:0]  ifm_out_fsm_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state;
  logic   load;
  logic   drop_pop;
  logic   beat_last;
  logic   good_done;
  logic   drop_done;
  logic   unused_info_bits;

  assign beat_last = data_fifo_rdata[72];

  // The output register may refill in the same cycle its current beat is accepted.
  assign load      = (state == S_FWD) && !data_fifo_empty && (!m_axis_tvalid || m_axis_tready);
  assign drop_pop  = (state == S_DROP) && !data_fifo_empty;
  assign good_done = load && beat_last;
  assign drop_done = drop_pop && beat_last;

  // Pops are held off while reset is asserted, before the state register has settled.
  assign info_fifo_rden = sys_rst_n && (state == S_IDLE) && out_en && !info_fifo_empty;
  assign data_fifo_rden = sys_rst_n && (load || drop_pop);

  assign ifm_out_fsm_dbg  = {2'b00, state};
  assign unused_info_bits = ^info_fifo_rdata[7:1];

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rx_clk) begin
    // NOTE: reset is synchronous; it is just the highest-priority branch of the clocked logic.
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (info_fifo_rden) state <= info_fifo_rdata[0] ? S_FWD : S_DROP;
        S_FWD:   if (good_done)      state <= S_IDLE;
        S_DROP:  if (drop_done)      state <= S_IDLE;
        default:                     state <= S_IDLE;
      endcase

      // A pending beat drains on tready in any state, so it is never dropped on a state change.
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= data_fifo_rdata[63:0];
        m_axis_tkeep  <= data_fifo_rdata[71:64];
        m_axis_tlast  <= beat_last;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef IFM_OUT_STATS_EN
  logic [31:0] good_cnt_q;
  logic [31:0] drop_cnt_q;

  // Clear has priority over a coincident increment; counters wrap naturally.
  always_ff @(posedge rx_clk) begin
    if (!sys_rst_n || stat_clr) begin
      good_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (good_done) good_cnt_q <= good_cnt_q + 32'd1;
      if (drop_done) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign frame_good_cnt = good_cnt_q;
  assign frame_drop_cnt = drop_cnt_q;
`else
  logic unused_stats;

  assign frame_good_cnt = 32'h0;
  assign frame_drop_cnt = 32'h0;
  assign unused_stats   = stat_clr ^ good_done ^ drop_done;
`endif

endmodule
